sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares the single off-chip SRAM data/address bus between two requesters:
//  A = CPU memory interface, B = video/DMA fetch. Sequences one access at a time,
//  drives SRAM strobes and controls the N-bit bidirectional tri-state buffer
//  (registered In->pad path, registered pad->Out path) including turnaround.
// PARAMETERS
//  N           16  data width (matches tri-state buffer width)
//  ADDR_W      20  SRAM word-address width
//  WAIT_CYCLES 2   length of ACCESS phase in clocks; legal range 1..15
// PORTS
//  Clk         in   1       system clock, all logic on posedge
//  Reset_n     in   1       synchronous, active-low reset
//  A_Req       in   1       A requests an access; hold until A_Gnt
//  A_Write     in   1       1 = write, 0 = read; sampled with A_Req
//  A_Addr      in   ADDR_W  word address; sampled with A_Req
//  A_WData     in   N       write data; sampled with A_Req
//  A_Gnt       out  1       1-cycle pulse: A's request accepted
//  A_Done      out  1       1-cycle pulse: A's access complete
//  A_RData     out  N       read data; valid with A_Done, held until next A read
//  B_*         --   --      identical set for requester B
//  SRAM_ADDR   out  ADDR_W  SRAM address
//  SRAM_CE_N   out  1       SRAM chip enable, active low
//  SRAM_OE_N   out  1       SRAM output enable, active low
//  SRAM_WE_N   out  1       SRAM write enable, active low
//  Tri_WE      out  1       tri-state buffer WriteEnable (1 = FPGA drives pad)
//  Tri_In      out  N       tri-state buffer In (write data)
//  Tri_Out     in   N       tri-state buffer Out (registered pad sample)
// BEHAVIOUR
//  - All outputs registered. Reset (Reset_n=0 at posedge): state IDLE, all *_N=1,
//    Tri_WE=0, Gnt/Done=0, RData=0, SRAM_ADDR=0, Tri_In=0, counter=0, RR ptr=B.
//  - Reset mid-access aborts immediately; no Done issued; requester re-requests.
//  - FSM: IDLE -> SETUP -> ACCESS (WAIT_CYCLES clks) -> DONE -> IDLE.
//  - IDLE: if any Req, arbitrate, latch winner Addr/Write/WData into SRAM_ADDR,
//    Tri_In, op reg; Gnt of winner high next cycle (during SETUP). No Req: stay.
//  - SETUP (1 clk): CE_N=0; OE_N=0 if read; Tri_WE=0. Tri_In stable so buffer's
//    output register holds write data by end of SETUP.
//  - ACCESS: CE_N=0; write: Tri_WE=1, WE_N=0, OE_N=1; read: OE_N=0, Tri_WE=0.
//    4-bit counter counts WAIT_CYCLES-1 down to 0, then DONE.
//  - DONE (1 clk): CE_N=OE_N=WE_N=1, Tri_WE=0 (bus turnaround cycle). Winner's
//    Done=1; on read, RData <= Tri_Out (pad value of last ACCESS cycle).
//  - Never Tri_WE=1 while OE_N=0; Tri_WE only high in ACCESS of a write.
//  - Latency Req(IDLE)->Done = WAIT_CYCLES+2 clks; back-to-back period WAIT_CYCLES+3.
//  - Req asserted outside IDLE is held pending, arbitrated on return to IDLE.
//    Req still high after Done = new transaction.
//  - Arbitration default: fixed priority, A beats B on simultaneous Req.
//  - SRAM_ADDR, Tri_In hold last values after DONE (no toggling while idle).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. 1-bit pointer = last-served requester, updated
//   at grant; on simultaneous Req the non-last-served wins; sole requester always
//   wins. Reset pointer = B, so A wins first tie.
//  ARB_RR_EN undefined: fixed priority A > B; no pointer register.
// TESTING
//  1 A write 0x00012<-0xBEEF, WAIT=2: A_Gnt @+1, WE_N=0 & Tri_WE=1 cycles +2..+3,
//    A_Done @+4, Tri_WE never 1 with OE_N=0.
//  2 A read 0x00012, SRAM model returns 0xBEEF: A_Done @+4, A_RData=0xBEEF held
//    after Done until next A read.
//  3 A_Req and B_Req same cycle, held: fixed -> A,A,A... B starved; ARB_RR_EN ->
//    A,B,A,B grants, each Done 5 clks apart (WAIT=2).
//  4 Reset_n=0 during ACCESS of B write: next cycle all *_N=1, Tri_WE=0, no B_Done;
//    B re-requests after release -> full normal access.
//  5 WAIT_CYCLES=1 and 15: Req->Done latency 3 and 17 clks respectively.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one off-chip SRAM bus between requester A (CPU) and
// requester B (video/DMA). One access at a time: IDLE -> SETUP -> ACCESS -> DONE.
// Drives the SRAM strobes and the tri-state buffer enable. All outputs are registered.
// Optional feature: define ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority with A ahead of B.
module sram_bus_arbiter #(
  parameter int unsigned N           = 16,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // requester A
  input  logic              i_a_req,
  input  logic              i_a_write,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [N-1:0]      i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_done,
  output logic [N-1:0]      o_a_rdata,
  // requester B
  input  logic              i_b_req,
  input  logic              i_b_write,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [N-1:0]      i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_done,
  output logic [N-1:0]      o_b_rdata,
  // SRAM and tri-state buffer
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_tri_we,
  output logic [N-1:0]      o_tri_in,
  input  logic [N-1:0]      i_tri_out
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_write;   // op of the current access
  logic                r_sel_b;   // 1 = current access belongs to B
  logic                r_a_gnt, r_b_gnt, r_a_done, r_b_done;
  logic [N-1:0]        r_a_rdata, r_b_rdata;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic                r_ce_n, r_oe_n, r_we_n, r_tri_we;
  logic [N-1:0]        r_tri_in;

  logic                w_a_wins;
  logic                w_b_wins;
  logic                w_win_write;

`ifdef ARB_RR_EN
  logic                r_ptr_b;   // last-served requester: 1 = B

  // Round-robin: on a tie the requester not served last wins
  always_comb begin
    w_a_wins = i_a_req && (!i_b_req || r_ptr_b);
    w_b_wins = i_b_req && !w_a_wins;
  end

  // Pointer tracks the last grant; reset to B so A wins the first tie
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr_b <= 1'b1;
    end else if (r_state == StIdle && (w_a_wins || w_b_wins)) begin
      r_ptr_b <= w_b_wins;
    end
  end
`else
  // Fixed priority: A beats B
  always_comb begin
    w_a_wins = i_a_req;
    w_b_wins = i_b_req && !i_a_req;
  end
`endif

  // Op type of whichever requester wins this cycle
  always_comb begin
    w_win_write = w_b_wins ? i_b_write : i_a_write;
  end

  // Access sequencer with registered strobes, pulses and read data
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_sel_b     <= 1'b0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_sram_addr <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_tri_we    <= 1'b0;
      r_tri_in    <= '0;
    end else begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_a_wins || w_b_wins) begin
            r_state     <= StSetup;
            r_sel_b     <= w_b_wins;
            r_write     <= w_win_write;
            r_sram_addr <= w_b_wins ? i_b_addr : i_a_addr;
            r_tri_in    <= w_b_wins ? i_b_wdata : i_a_wdata;
            r_a_gnt     <= w_a_wins;
            r_b_gnt     <= w_b_wins;
            r_ce_n      <= 1'b0;
            r_oe_n      <= w_win_write;
            r_we_n      <= 1'b1;
            r_tri_we    <= 1'b0;
          end
        end
        StSetup: begin
          // Buffer output register now holds write data; safe to drive the pad
          r_state  <= StAccess;
          r_cnt    <= CntInit;
          r_oe_n   <= r_write;
          r_we_n   <= !r_write;
          r_tri_we <= r_write;
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            // Release the bus for one turnaround cycle
            r_state  <= StDone;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_tri_we <= 1'b0;
            r_a_done <= !r_sel_b;
            r_b_done <= r_sel_b;
            if (!r_write) begin
              if (r_sel_b) begin
                r_b_rdata <= i_tri_out;
              end else begin
                r_a_rdata <= i_tri_out;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_a_gnt     = r_a_gnt;
  assign o_b_gnt     = r_b_gnt;
  assign o_a_done    = r_a_done;
  assign o_b_done    = r_b_done;
  assign o_a_rdata   = r_a_rdata;
  assign o_b_rdata   = r_b_rdata;
  assign o_sram_addr = r_sram_addr;
  assign o_sram_ce_n = r_ce_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_we_n = r_we_n;
  assign o_tri_we    = r_tri_we;
  assign o_tri_in    = r_tri_in;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: transaction-level reference model plus SRAM/buffer
// environment, directed cases and randomized requester traffic.
module tb_sram_bus_arbiter;
  localparam int N  = 16;
  localparam int AW = 20;
  localparam int W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, a_write, b_req, b_write;
  logic [AW-1:0] a_addr, b_addr;
  logic [N-1:0]  a_wdata, b_wdata;
  logic          o_a_gnt, o_a_done, o_b_gnt, o_b_done;
  logic [N-1:0]  o_a_rdata, o_b_rdata;
  logic [AW-1:0] o_sram_addr;
  logic          o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_tri_we;
  logic [N-1:0]  o_tri_in;
  logic [N-1:0]  tri_out;

  int errors = 0;
  int checks = 0;
  bit model_en = 1'b0;

  sram_bus_arbiter #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(a_req), .i_a_write(a_write), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(o_a_gnt), .o_a_done(o_a_done), .o_a_rdata(o_a_rdata),
    .i_b_req(b_req), .i_b_write(b_write), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(o_b_gnt), .o_b_done(o_b_done), .o_b_rdata(o_b_rdata),
    .o_sram_addr(o_sram_addr), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_we_n(o_sram_we_n), .o_tri_we(o_tri_we), .o_tri_in(o_tri_in),
    .i_tri_out(tri_out)
  );

  // Extra instances for the WAIT_CYCLES extremes (latency only)
  logic          s1_req, s15_req;
  logic          s1_gnt, s1_done, s1_bg, s1_bd, s1_ce, s1_oe, s1_we, s1_twe;
  logic          s15_gnt, s15_done, s15_bg, s15_bd, s15_ce, s15_oe, s15_we, s15_twe;
  logic [N-1:0]  s1_ard, s1_brd, s1_tin, s15_ard, s15_brd, s15_tin;
  logic [AW-1:0] s1_addr, s15_addr;

  sram_bus_arbiter #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(1)) dut_w1 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(s1_req), .i_a_write(1'b1), .i_a_addr(20'h00005), .i_a_wdata(16'h1234),
    .o_a_gnt(s1_gnt), .o_a_done(s1_done), .o_a_rdata(s1_ard),
    .i_b_req(1'b0), .i_b_write(1'b0), .i_b_addr('0), .i_b_wdata('0),
    .o_b_gnt(s1_bg), .o_b_done(s1_bd), .o_b_rdata(s1_brd),
    .o_sram_addr(s1_addr), .o_sram_ce_n(s1_ce), .o_sram_oe_n(s1_oe),
    .o_sram_we_n(s1_we), .o_tri_we(s1_twe), .o_tri_in(s1_tin), .i_tri_out(16'h0000)
  );

  sram_bus_arbiter #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(15)) dut_w15 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(s15_req), .i_a_write(1'b1), .i_a_addr(20'h00007), .i_a_wdata(16'h4321),
    .o_a_gnt(s15_gnt), .o_a_done(s15_done), .o_a_rdata(s15_ard),
    .i_b_req(1'b0), .i_b_write(1'b0), .i_b_addr('0), .i_b_wdata('0),
    .o_b_gnt(s15_bg), .o_b_done(s15_bd), .o_b_rdata(s15_brd),
    .o_sram_addr(s15_addr), .o_sram_ce_n(s15_ce), .o_sram_oe_n(s15_oe),
    .o_sram_we_n(s15_we), .o_tri_we(s15_twe), .o_tri_in(s15_tin), .i_tri_out(16'h0000)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] init_pat(input int i);
    return 16'(i * 16'h1111 ^ 16'h5A5A);
  endfunction

  // SRAM + buffer environment: writes land while WE_N is low and the pad is driven;
  // the buffer output register samples the pad each clock (junk when nobody drives)
  logic [N-1:0] env_mem [32];
  bit env_seeded = 1'b0;
  always @(posedge clk) begin
    if (!env_seeded) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_pat(i);
      env_seeded <= 1'b1;
    end else if (!o_sram_ce_n && !o_sram_we_n && o_tri_we) begin
      env_mem[o_sram_addr[4:0]] <= o_tri_in;
    end
    tri_out <= (!o_sram_ce_n && !o_sram_oe_n) ? env_mem[o_sram_addr[4:0]] : N'($urandom);
  end

  // Reference model: one transaction in flight, tracked by its age m_k
  // (0 = setup, 1..W = access, W+1 = done cycle)
  bit            m_busy = 1'b0;
  int            m_k = 0;
  bit            m_sel, m_wr, m_ptr, m_seeded = 1'b0, m_s;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_wd;
  logic [N-1:0]  m_rd [2];
  logic [N-1:0]  ref_mem [32];

  always @(posedge clk) begin
    if (!m_seeded) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = init_pat(i);
      m_seeded = 1'b1;
    end
    if (m_busy && m_wr && m_k >= 1 && m_k <= W) ref_mem[m_addr[4:0]] = m_wd;
    if (!rst_n) begin
      m_busy = 1'b0; m_k = 0; m_addr = '0; m_wd = '0;
      m_rd[0] = '0; m_rd[1] = '0; m_ptr = 1'b1; m_sel = 1'b0; m_wr = 1'b0;
    end else if (m_busy) begin
      if (m_k == W && !m_wr) m_rd[m_sel] = ref_mem[m_addr[4:0]];
      if (m_k == W + 1) m_busy = 1'b0;
      else m_k++;
    end else if (a_req || b_req) begin
`ifdef ARB_RR_EN
      m_s = (a_req && b_req) ? !m_ptr : b_req;
`else
      m_s = !a_req;
`endif
      m_ptr = m_s; m_sel = m_s; m_busy = 1'b1; m_k = 0;
      m_wr = m_s ? b_write : a_write;
      m_addr = m_s ? b_addr : a_addr;
      m_wd = m_s ? b_wdata : a_wdata;
    end
  end

  // Per-cycle compare of every DUT output against the model
  logic ph_on, ph_acc;
  always @(negedge clk) begin
    if (model_en) begin
      ph_on  = m_busy && m_k <= W;
      ph_acc = m_busy && m_k >= 1 && m_k <= W;
      check("a_gnt", 32'(o_a_gnt), 32'(m_busy && m_k == 0 && !m_sel));
      check("b_gnt", 32'(o_b_gnt), 32'(m_busy && m_k == 0 && m_sel));
      check("a_done", 32'(o_a_done), 32'(m_busy && m_k == W + 1 && !m_sel));
      check("b_done", 32'(o_b_done), 32'(m_busy && m_k == W + 1 && m_sel));
      check("a_rdata", 32'(o_a_rdata), 32'(m_rd[0]));
      check("b_rdata", 32'(o_b_rdata), 32'(m_rd[1]));
      check("ce_n", 32'(o_sram_ce_n), 32'(!ph_on));
      check("oe_n", 32'(o_sram_oe_n), 32'(!(ph_on && !m_wr)));
      check("we_n", 32'(o_sram_we_n), 32'(!(ph_acc && m_wr)));
      check("tri_we", 32'(o_tri_we), 32'(ph_acc && m_wr));
      check("sram_addr", 32'(o_sram_addr), 32'(m_addr));
      check("tri_in", 32'(o_tri_in), 32'(m_wd));
      check("bus_conflict", 32'(o_tri_we && !o_sram_oe_n), 32'd0);
    end
  end

  // One transaction on requester sel; records cycle offsets from the request cycle
  task automatic run_txn(input bit sel, input bit wr, input logic [AW-1:0] ad,
                         input logic [N-1:0] d, output int gnt_c, output int done_c,
                         output int we_first, output int we_cnt);
    int c = 0;
    gnt_c = -1; done_c = -1; we_first = -1; we_cnt = 0;
    @(posedge clk); #1;
    if (sel) begin b_req = 1; b_write = wr; b_addr = ad; b_wdata = d; end
    else begin a_req = 1; a_write = wr; a_addr = ad; a_wdata = d; end
    while (c < 60) begin
      @(negedge clk);
      if (!sel && o_a_gnt) begin gnt_c = c; a_req = 0; end
      if (sel && o_b_gnt) begin gnt_c = c; b_req = 0; end
      if (!o_sram_we_n && o_tri_we) begin
        if (we_first < 0) we_first = c;
        we_cnt++;
      end
      if ((!sel && o_a_done) || (sel && o_b_done)) begin done_c = c; break; end
      c++;
    end
    if (done_c < 0) check("txn_timeout", 32'd0, 32'd1);
    a_req = 0; b_req = 0;
  endtask

  task automatic drive_rand(input bit sel);
    bit req = sel ? b_req : a_req;
    bit g   = sel ? o_b_gnt : o_a_gnt;
    bit nreq = req;
    if (req && g) nreq = ($urandom_range(0, 3) == 0);
    else if (!req) nreq = ($urandom_range(0, 2) == 0);
    if (sel) b_req = nreq; else a_req = nreq;
    if (nreq && (!req || g)) begin
      if (sel) begin
        b_write = 1'($urandom_range(0, 1)); b_addr = AW'($urandom); b_wdata = N'($urandom);
      end else begin
        a_write = 1'($urandom_range(0, 1)); a_addr = AW'($urandom); a_wdata = N'($urandom);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, d, wf, wc, c, d1, d15;
    int gq[$];
    int dq[$];
    bit saw_done;
    rst_n = 0; a_req = 0; b_req = 0; a_write = 0; b_write = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; s1_req = 0; s15_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_en = 1'b1;
    rst_n = 1;

    // Write 0x00012 <- 0xBEEF
    run_txn(0, 1, 20'h00012, 16'hBEEF, g, d, wf, wc);
    check("wr_gnt_cycle", 32'(g), 32'd1);
    check("wr_done_cycle", 32'(d), 32'd4);
    check("wr_we_first", 32'(wf), 32'd2);
    check("wr_we_count", 32'(wc), 32'd2);

    // Read back
    run_txn(0, 0, 20'h00012, 16'h0000, g, d, wf, wc);
    check("rd_done_cycle", 32'(d), 32'd4);
    check("rd_data", 32'(o_a_rdata), 32'h0000BEEF);
    check("rd_no_we", 32'(wc), 32'd0);
    // B traffic must leave A_RData alone
    run_txn(1, 1, 20'h00003, 16'h7777, g, d, wf, wc);
    run_txn(1, 0, 20'h00003, 16'h0000, g, d, wf, wc);
    check("b_rd_data", 32'(o_b_rdata), 32'h00007777);
    check("a_rdata_held", 32'(o_a_rdata), 32'h0000BEEF);

    // Simultaneous held requests
    @(posedge clk); #1;
    a_req = 1; a_write = 1; a_addr = 20'h00001; a_wdata = 16'hAAAA;
    b_req = 1; b_write = 1; b_addr = 20'h00002; b_wdata = 16'hBBBB;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (o_a_gnt) gq.push_back(0);
      if (o_b_gnt) gq.push_back(1);
      if (o_a_done || o_b_done) dq.push_back(i);
    end
    a_req = 0; b_req = 0;
    check("tie_grants", 32'(gq.size()), 32'd4);
    check("tie_dones", 32'(dq.size()), 32'd3);
    if (gq.size() == 4 && dq.size() == 3) begin
`ifdef ARB_RR_EN
      check("tie_g0", 32'(gq[0]), 32'd0);
      check("tie_g1", 32'(gq[1]), 32'd1);
      check("tie_g2", 32'(gq[2]), 32'd0);
      check("tie_g3", 32'(gq[3]), 32'd1);
`else
      check("tie_g0", 32'(gq[0]), 32'd0);
      check("tie_g1", 32'(gq[1]), 32'd0);
      check("tie_g2", 32'(gq[2]), 32'd0);
      check("tie_g3", 32'(gq[3]), 32'd0);
`endif
      check("tie_done0", 32'(dq[0]), 32'd4);
      check("tie_period1", 32'(dq[1] - dq[0]), 32'd5);
      check("tie_period2", 32'(dq[2] - dq[1]), 32'd5);
    end
    repeat (12) @(posedge clk);

    // Reset during ACCESS of a B write
    @(posedge clk); #1;
    b_req = 1; b_write = 1; b_addr = 20'h00009; b_wdata = 16'hC0DE;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      if (o_b_gnt) b_req = 0;
      if (!o_sram_we_n) break;
      c++;
    end
    check("rst_reached_access", 32'(c < 20), 32'd1);
    rst_n = 0;
    @(negedge clk);
    check("rst_ce_n", 32'(o_sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(o_sram_oe_n), 32'd1);
    check("rst_we_n", 32'(o_sram_we_n), 32'd1);
    check("rst_tri_we", 32'(o_tri_we), 32'd0);
    rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_b_done) saw_done = 1;
    end
    check("rst_no_b_done", 32'(saw_done), 32'd0);
    run_txn(1, 1, 20'h00009, 16'hC0DE, g, d, wf, wc);
    check("rst_retry_done", 32'(d), 32'd4);
    run_txn(1, 0, 20'h00009, 16'h0000, g, d, wf, wc);
    check("rst_retry_data", 32'(o_b_rdata), 32'h0000C0DE);

    // WAIT_CYCLES extremes
    @(posedge clk); #1;
    s1_req = 1; s15_req = 1; c = 0; d1 = -1; d15 = -1;
    while (c < 40 && (d1 < 0 || d15 < 0)) begin
      @(negedge clk);
      if (s1_gnt) s1_req = 0;
      if (s15_gnt) s15_req = 0;
      if (s1_done && d1 < 0) d1 = c;
      if (s15_done && d15 < 0) d15 = c;
      c++;
    end
    s1_req = 0; s15_req = 0;
    check("lat_w1", 32'(d1), 32'd3);
    check("lat_w15", 32'(d15), 32'd17);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      drive_rand(0);
      drive_rand(1);
    end
    a_req = 0; b_req = 0;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
